// File: rtl/alu_result_stage.sv
// Result stage behind the ALU function units: a 2-entry FIFO of {result, flags, dest, setflags}
// handed to writeback over valid/ready, committing Z/N/C/V into the architectural flag register on pop.
module alu_result_stage #(
    parameter int WIDTH  = 16,
    parameter int DEST_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_result,
    input  logic              in_z,
    input  logic              in_n,
    input  logic              in_c,
    input  logic              in_v,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              in_setflags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic [DEST_W-1:0] out_dest,
    input  logic              flags_wr_en,
    input  logic [3:0]        flags_wr_data,
    output logic [3:0]        flags,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic [WIDTH-1:0]  result;
        logic [3:0]        zncv;
        logic [DEST_W-1:0] dest;
        logic              setflags;
    } entry_t;

    entry_t            slot_q [2];
    entry_t            slot_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        occ_q, occ_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_result_q, out_result_d;
    logic [DEST_W-1:0] out_dest_q, out_dest_d;
    logic [3:0]        flags_q, flags_d;

    logic              push_s;
    logic              pop_s;
    entry_t            in_entry_s;
    entry_t            head_s;
    entry_t            next_head_s;

    // Next-state logic: FIFO bookkeeping, head presentation and flag commit.
    always_comb begin
        push_s      = in_valid & in_ready_q;
        pop_s       = out_valid_q & out_ready;
        in_entry_s  = '{result: in_result, zncv: {in_z, in_n, in_c, in_v},
                        dest: in_dest, setflags: in_setflags};
        head_s      = slot_q[rd_ptr_q];
        slot_d      = slot_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        flags_d     = flags_q;

        if (push_s) begin
            slot_d[wr_ptr_q] = in_entry_s;
            wr_ptr_d         = wr_ptr_q ^ 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q ^ 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        // slot_d already holds a same-cycle push, so a fresh entry landing in an emptied stage shows up here.
        next_head_s = slot_d[rd_ptr_d];
        if (occ_d != 2'd0) begin
            out_result_d = next_head_s.result;
            out_dest_d   = next_head_s.dest;
        end else begin
            out_result_d = out_result_q;
            out_dest_d   = out_dest_q;
        end

        if (flags_wr_en) begin
            flags_d = flags_wr_data;
        end else if (pop_s && head_s.setflags) begin
            flags_d = head_s.zncv;
        end else begin
            flags_d = flags_q;
        end

        in_ready_d  = (occ_d != 2'd2);
        out_valid_d = (occ_d != 2'd0);
    end

    // State registers; reset discards any in-flight entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q[0]    <= '0;
            slot_q[1]    <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            occ_q        <= 2'd0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_dest_q   <= '0;
            flags_q      <= 4'b0000;
        end else begin
            slot_q[0]    <= slot_d[0];
            slot_q[1]    <= slot_d[1];
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_dest_q   <= out_dest_d;
            flags_q      <= flags_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_dest   = out_dest_q;
    assign flags      = flags_q;
    assign occupancy  = occ_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios plus a randomized run checked against
// a queue-based reference model of the 2-entry buffer and the flag register.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] in_result;
    logic        in_z, in_n, in_c, in_v;
    logic [2:0]  in_dest;
    logic        in_setflags;
    logic        out_valid, out_ready;
    logic [15:0] out_result;
    logic [2:0]  out_dest;
    logic        flags_wr_en;
    logic [3:0]  flags_wr_data;
    logic [3:0]  flags;
    logic [1:0]  occupancy;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [15:0] r;
        logic [3:0]  f;
        logic [2:0]  d;
        logic        s;
    } ent_t;

    ent_t        q[$];
    logic [3:0]  m_flags = 4'b0000;
    logic [15:0] m_res   = 16'h0000;
    logic [2:0]  m_dest  = 3'd0;

    alu_result_stage #(.WIDTH(16), .DEST_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_z(in_z), .in_n(in_n), .in_c(in_c), .in_v(in_v),
        .in_dest(in_dest), .in_setflags(in_setflags),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_dest(out_dest),
        .flags_wr_en(flags_wr_en), .flags_wr_data(flags_wr_data),
        .flags(flags), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [15:0] r, input logic [3:0] f,
                         input logic [2:0] d, input logic s, input logic ordy);
        in_valid    = v;
        in_result   = r;
        {in_z, in_n, in_c, in_v} = f;
        in_dest     = d;
        in_setflags = s;
        out_ready   = ordy;
    endtask

    // Advance one clock, updating the reference model from the inputs present at the edge.
    task automatic tick();
        bit   psh, pp;
        ent_t e, gone;
        psh = in_valid && (q.size() != 2);
        pp  = (q.size() != 0) && out_ready;
        if (flags_wr_en) m_flags = flags_wr_data;
        else if (pp && q[0].s) m_flags = q[0].f;
        e = '{r: in_result, f: {in_z, in_n, in_c, in_v}, d: in_dest, s: in_setflags};
        if (pp) gone = q.pop_front();
        if (psh) q.push_back(e);
        if (q.size() != 0) begin
            m_res  = q[0].r;
            m_dest = q[0].d;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flags_wr_en = 1'b0;
        flags_wr_data = 4'b0000;
        drive(1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (occupancy !== 2'd0) $display("FAIL reset_occ got %0d exp 0", occupancy); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
        n_total++; if (flags !== 4'b0000) $display("FAIL reset_flags got %b exp 0000", flags); else n_pass++;
        n_total++; if (out_result !== 16'h0000) $display("FAIL reset_result got %h exp 0000", out_result); else n_pass++;
        n_total++; if (out_dest !== 3'd0) $display("FAIL reset_dest got %0d exp 0", out_dest); else n_pass++;
        rst_n = 1'b1;
        #2;
    endtask

    task automatic test_basic();
        drive(1'b1, 16'hF0F0, 4'b0100, 3'd5, 1'b1, 1'b1);
        tick();
        n_total++; if (out_valid !== 1'b1) $display("FAIL basic_valid got %b exp 1", out_valid); else n_pass++;
        n_total++; if (out_result !== 16'hF0F0) $display("FAIL basic_result got %h exp f0f0", out_result); else n_pass++;
        n_total++; if (out_dest !== 3'd5) $display("FAIL basic_dest got %0d exp 5", out_dest); else n_pass++;
        n_total++; if (flags !== 4'b0000) $display("FAIL basic_flags_at_push got %b exp 0000", flags); else n_pass++;
        drive(1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b1);
        tick();
        n_total++; if (flags !== 4'b0100) $display("FAIL basic_flags_commit got %b exp 0100", flags); else n_pass++;
        n_total++; if (occupancy !== 2'd0) $display("FAIL basic_occ got %0d exp 0", occupancy); else n_pass++;
        n_total++; if (out_result !== 16'hF0F0) $display("FAIL basic_hold got %h exp f0f0", out_result); else n_pass++;
    endtask

    task automatic test_full();
        drive(1'b1, 16'h0001, 4'h0, 3'd1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0002, 4'h0, 3'd2, 1'b0, 1'b0);
        tick();
        n_total++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got %b exp 0", in_ready); else n_pass++;
        n_total++; if (occupancy !== 2'd2) $display("FAIL full_occ got %0d exp 2", occupancy); else n_pass++;
        drive(1'b1, 16'h0003, 4'h0, 3'd3, 1'b0, 1'b0);
        tick();
        n_total++; if (occupancy !== 2'd2) $display("FAIL full_ignore_occ got %0d exp 2", occupancy); else n_pass++;
        n_total++; if (out_result !== 16'h0001) $display("FAIL full_head_stable got %h exp 0001", out_result); else n_pass++;
        drive(1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b1);
        tick();
        n_total++; if (out_result !== 16'h0002) $display("FAIL full_second got %h exp 0002", out_result); else n_pass++;
        n_total++; if (out_dest !== 3'd2) $display("FAIL full_second_dest got %0d exp 2", out_dest); else n_pass++;
        tick();
        n_total++; if (occupancy !== 2'd0) $display("FAIL full_drain_occ got %0d exp 0", occupancy); else n_pass++;
        n_total++; if (out_result !== 16'h0002) $display("FAIL full_no_third got %h exp 0002", out_result); else n_pass++;
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 16'h00AA, 4'h0, 3'd1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h00BB, 4'h0, 3'd2, 1'b0, 1'b1);
        tick();
        n_total++; if (occupancy !== 2'd1) $display("FAIL simul_occ got %0d exp 1", occupancy); else n_pass++;
        n_total++; if (out_result !== 16'h00BB) $display("FAIL simul_head got %h exp 00bb", out_result); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'h0100 + 16'(i), 4'h0, 3'(i), 1'b0, 1'b1);
            tick();
            n_total++;
            if (out_result !== 16'h0100 + 16'(i) || occupancy !== 2'd1)
                $display("FAIL simul_stream[%0d] got %h/occ %0d exp %h/occ 1", i, out_result, occupancy, 16'h0100 + 16'(i));
            else n_pass++;
        end
        drive(1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b1);
        tick();
        n_total++; if (occupancy !== 2'd0) $display("FAIL simul_drain got %0d exp 0", occupancy); else n_pass++;
    endtask

    task automatic test_flags_nochange();
        drive(1'b1, 16'h1234, 4'b1000, 3'd4, 1'b0, 1'b1);
        tick();
        drive(1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b1);
        tick();
        n_total++; if (flags !== 4'b0100) $display("FAIL nosetflags got %b exp 0100", flags); else n_pass++;
        n_total++; if (occupancy !== 2'd0) $display("FAIL nosetflags_occ got %0d exp 0", occupancy); else n_pass++;
    endtask

    task automatic test_direct_write();
        drive(1'b1, 16'h5555, 4'b1000, 3'd6, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b1);
        flags_wr_en = 1'b1;
        flags_wr_data = 4'b0011;
        tick();
        flags_wr_en = 1'b0;
        n_total++; if (flags !== 4'b0011) $display("FAIL direct_wins got %b exp 0011", flags); else n_pass++;
        n_total++; if (occupancy !== 2'd0) $display("FAIL direct_consumed got %0d exp 0", occupancy); else n_pass++;
    endtask

    task automatic test_async_reset();
        drive(1'b1, 16'hAAAA, 4'b1111, 3'd7, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'hBBBB, 4'b1111, 3'd6, 1'b1, 1'b0);
        tick();
        n_total++; if (occupancy !== 2'd2) $display("FAIL arst_pre_occ got %0d exp 2", occupancy); else n_pass++;
        drive(1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL arst_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL arst_in_ready got %b exp 1", in_ready); else n_pass++;
        n_total++; if (occupancy !== 2'd0) $display("FAIL arst_occ got %0d exp 0", occupancy); else n_pass++;
        n_total++; if (flags !== 4'b0000) $display("FAIL arst_flags got %b exp 0000", flags); else n_pass++;
        q.delete();
        m_flags = 4'b0000;
        m_res   = 16'h0000;
        m_dest  = 3'd0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        drive(1'b1, 16'hC0DE, 4'b0010, 3'd3, 1'b0, 1'b0);
        tick();
        n_total++; if (out_valid !== 1'b1 || out_result !== 16'hC0DE)
            $display("FAIL arst_latency got valid %b result %h exp 1 c0de", out_valid, out_result); else n_pass++;
        drive(1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), 16'($urandom), 4'($urandom), 3'($urandom),
                  1'($urandom), ($urandom_range(0, 2) != 0));
            flags_wr_en   = ($urandom_range(0, 7) == 0);
            flags_wr_data = 4'($urandom);
            tick();
            n_total++; if (occupancy !== 2'(q.size())) $display("FAIL rand_occ[%0d] got %0d exp %0d", i, occupancy, q.size()); else n_pass++;
            n_total++; if (out_valid !== (q.size() != 0)) $display("FAIL rand_valid[%0d] got %b", i, out_valid); else n_pass++;
            n_total++; if (in_ready !== (q.size() != 2)) $display("FAIL rand_in_ready[%0d] got %b", i, in_ready); else n_pass++;
            n_total++; if (out_result !== m_res) $display("FAIL rand_result[%0d] got %h exp %h", i, out_result, m_res); else n_pass++;
            n_total++; if (out_dest !== m_dest) $display("FAIL rand_dest[%0d] got %0d exp %0d", i, out_dest, m_dest); else n_pass++;
            n_total++; if (flags !== m_flags) $display("FAIL rand_flags[%0d] got %b exp %b", i, flags, m_flags); else n_pass++;
        end
        flags_wr_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_simultaneous();
        test_flags_nochange();
        test_direct_write();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
